imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: SYNC_BYTE, default 8'hA5, header byte that starts a load frame.
REQ-002 Parameter: MAX_WORDS, default 32, capacity of the 7-bit byte-addressed instruction memory in words.
REQ-003 Port: clk  input  1  processor-domain clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  host byte-stream valid.
REQ-006 Port: in_data  input  8  host byte.
REQ-007 Port: in_ready  output  1  loader accepts in_data this cycle; a byte is consumed only when in_valid && in_ready.
REQ-008 Port: mem_we  output  1  instruction-memory write strobe, one-cycle pulse per word.
REQ-009 Port: mem_addr  output  7  instruction-memory byte address, always word-aligned (bits [1:0] = 0).
REQ-010 Port: mem_wdata  output  32  instruction word to write.
REQ-011 Port: cpu_hold  output  1  holds the processor program counter and pipeline while a load is in progress.
REQ-012 Port: load_done  output  1  last frame completed with a good checksum.
REQ-013 Port: load_error  output  1  last frame aborted with a bad count or bad checksum.
REQ-014 Port: words_written  output  6  number of words written in the current or last frame.

Function
REQ-015 Frame format: SYNC_BYTE, COUNT (number of words, N), 4*N data bytes (big-endian, MSB byte first), CHK.
REQ-016 The FSM states SHALL be IDLE, COUNT, DATA, CHECK, DONE, ERROR.
REQ-017 in_ready SHALL be 1 in every state; the loader never back-pressures.
REQ-018 IDLE/DONE/ERROR: on an accepted byte equal to SYNC_BYTE -> COUNT. In the same cycle: assert cpu_hold; clear load_done, load_error, words_written, checksum, word index. Other bytes are discarded and the state is held.
REQ-019 COUNT: an accepted byte N with 1 <= N <= MAX_WORDS -> DATA. N = 0 or N > MAX_WORDS -> ERROR.
REQ-020 DATA: accepted bytes shift into a 32-bit assembly register, MSB first. Every data byte is XORed into an 8-bit checksum.
REQ-021 The 4th byte of a word SHALL be accepted at cycle T. At cycle T+1, mem_we = 1 for exactly one cycle, with:
  - mem_addr = word_index*4
  - mem_wdata = the assembled word
  - words_written incremented
REQ-022 After word N-1 is accepted -> CHECK. Byte arrival gaps of any length (in_valid low) SHALL be tolerated in every state.
REQ-023 CHECK: accepted byte equal to the running checksum -> DONE; otherwise -> ERROR.
REQ-024 Words already written before an ERROR SHALL NOT be rolled back.
REQ-025 DONE: cpu_hold = 0, load_done = 1. ERROR: cpu_hold = 0, load_error = 1. load_done and load_error SHALL never be 1 simultaneously.
REQ-026 A SYNC_BYTE value arriving in COUNT, DATA or CHECK SHALL be treated as ordinary frame data; there is no resync mid-frame.
REQ-027 mem_we SHALL be 0 whenever the state is not DATA or CHECK, except for the final-word pulse issued on the cycle after the state has moved to CHECK.
REQ-028 mem_addr and mem_wdata SHALL hold their last values when mem_we = 0.

Reset
REQ-029 On reset: state = IDLE; in_ready = 1; mem_we = 0; mem_addr = 0; mem_wdata = 0; cpu_hold = 0; load_done = 0; load_error = 0; words_written = 0; checksum = 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no further mem_we pulse, including a pending pulse scheduled for the next cycle.

Structure
REQ-031 State encoding, SYNC_BYTE default and MAX_WORDS default SHALL live in the shared processor package, so the top-level and the bench use the same constants.
REQ-032 Byte assembly plus checksum SHALL be one sub-module, imem_word_assembler. It is fed by accepted bytes and provides word_valid, word, and chk.
REQ-033 The FSM, address counter and status flags SHALL live in imem_loader.

Verification
REQ-034 Bytes A5 01 12 34 56 78 08 -> single mem_we with addr 0, data 0x12345678; then load_done = 1, words_written = 1, cpu_hold = 0.
REQ-035 A5 02, words 0x20080005 and 0x00000000, CHK 0x2D -> mem_we at addr 0 then addr 4; load_done = 1.
REQ-036 A5 00 -> ERROR, load_error = 1, no mem_we; A5 21 -> ERROR, no mem_we.
REQ-037 A5 01 DE AD BE EF 00 -> one write of 0xDEADBEEF, then load_error = 1 (expected CHK 0x22).
REQ-038 Reset asserted after the 2nd data byte of A5 01 -> no mem_we, all outputs at reset values; a subsequent full valid frame completes normally.
REQ-039 Bytes FF 00 A5 01 00 00 00 A5 A5 with random in_valid gaps -> leading FF 00 ignored, one write of 0x000000A5, load_done = 1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants and types for the instruction-memory loader.
// The FSM state encoding and the default frame constants live here so that the
// loader and anything driving it agree on the same values.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         MAX_WORDS_DEF = 32;

  localparam int ADDR_W = 7;   // byte address into the instruction memory
  localparam int WCNT_W = 6;   // word counter wide enough to hold MAX_WORDS

  // Word index -> word-aligned byte address.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-3:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream plus instruction-memory write bus.
//   in_valid/in_data/in_ready : host -> loader byte stream
//   mem_we/mem_addr/mem_wdata : loader -> instruction memory write port
// master = host / memory side, slave = loader.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_word_assembler.sv
// Big-endian byte-to-word assembler with running XOR checksum.
//   clk, reset  : clock, synchronous active-high reset
//   clear       : start of a new frame; drops partial word and checksum
//   byte_valid  : byte_in is a frame data byte accepted this cycle
//   byte_in     : data byte
//   word_valid  : this cycle's byte completes a word (combinational)
//   word        : completed word, valid with word_valid
//   chk         : XOR of all data bytes accepted since the last clear
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [7:0]  chk
);

  logic [23:0] sr;    // first three bytes of the word in progress
  logic [1:0]  cnt;   // bytes already held in sr

  // The word is presented on the same cycle as its fourth byte so the
  // loader can register it straight into the memory write port.
  assign word_valid = byte_valid && (cnt == 2'd3);
  assign word       = {sr, byte_in};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sr  <= '0;
      cnt <= '0;
      chk <= '0;
    end else if (byte_valid) begin
      sr  <= {sr[15:0], byte_in};
      cnt <= cnt + 2'd1;
      chk <= chk ^ byte_in;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads instruction words from a host byte stream into instruction memory.
// Frame: SYNC_BYTE, N, 4*N big-endian data bytes, XOR checksum byte.
//   clk, reset     : clock, synchronous active-high reset
//   bus (slave)    : byte stream in, memory write port out
//   cpu_hold       : processor held while a frame is in progress
//   load_done      : last frame finished with a good checksum
//   load_error     : last frame aborted (bad count or bad checksum)
//   words_written  : words written in the current or last frame
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  imem_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [WCNT_W-1:0] words_written
);

  localparam logic [7:0] MAX_W8 = 8'(MAX_WORDS);

  state_e            state, state_nxt;
  logic              acc;
  logic              start;
  logic              count_ok;
  logic              last_word;
  logic [WCNT_W-1:0] n_words;

  logic              word_valid;
  logic [31:0]       word;
  logic [7:0]        chk;

  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;

  // Never back-pressures: every valid byte is consumed.
  assign bus.in_ready  = 1'b1;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign acc = bus.in_valid;

  // Sync is only recognised between frames; inside a frame it is plain data.
  assign start = acc && (bus.in_data == SYNC_BYTE) &&
                 (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);

  assign count_ok  = (bus.in_data != 8'd0) && (bus.in_data <= MAX_W8);

  // words_written still holds this word's index on the accept cycle.
  assign last_word = word_valid && (words_written == n_words - 6'd1);

  imem_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (start),
    .byte_valid (acc && state == ST_DATA),
    .byte_in    (bus.in_data),
    .word_valid (word_valid),
    .word       (word),
    .chk        (chk)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) state_nxt = ST_COUNT;
      ST_COUNT: if (acc) state_nxt = count_ok ? ST_DATA : ST_ERROR;
      ST_DATA:  if (last_word) state_nxt = ST_CHECK;
      ST_CHECK: if (acc) state_nxt = (bus.in_data == chk) ? ST_DONE : ST_ERROR;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Status is a pure decode of the state, so done/error are exclusive.
  assign cpu_hold   = (state == ST_COUNT) || (state == ST_DATA) || (state == ST_CHECK);
  assign load_done  = (state == ST_DONE);
  assign load_error = (state == ST_ERROR);

  // Write port is registered: word completes at T, pulse appears at T+1.
  // A synchronous reset on that edge suppresses the pending pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      words_written <= '0;
      n_words       <= '0;
    end else begin
      mem_we_q <= 1'b0;
      if (start) words_written <= '0;
      if (state == ST_COUNT && acc) n_words <= bus.in_data[WCNT_W-1:0];
      if (word_valid) begin
        mem_we_q      <= 1'b1;
        mem_addr_q    <= word_addr(words_written[ADDR_W-3:0]);
        mem_wdata_q   <= word;
        words_written <= words_written + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_hold, load_done, load_error;
  logic [5:0] words_written;

  always #5 clk = ~clk;

  imem_loader_if bus ();

  imem_loader dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .cpu_hold      (cpu_hold),
    .load_done     (load_done),
    .load_error    (load_error),
    .words_written (words_written)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [6:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t wlog[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: tracks where we are in the frame by counting bytes.
  logic        m_active = 1'b0, m_haven = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic        m_we = 1'b0;
  int          m_n = 0;
  int          m_ww = 0;
  logic [6:0]  m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [7:0]  m_bytes[$];

  always @(posedge clk) begin
    logic [7:0] b, x;
    int sz;
    m_we = 1'b0;
    if (reset) begin
      m_active = 0; m_haven = 0; m_done = 0; m_err = 0;
      m_ww = 0; m_addr = '0; m_wdata = '0;
      m_bytes.delete();
    end else if (bus.in_valid) begin
      b = bus.in_data;
      if (!m_active) begin
        if (b == SYNC_BYTE_DEF) begin
          m_active = 1; m_haven = 0; m_done = 0; m_err = 0; m_ww = 0;
          m_bytes.delete();
        end
      end else if (!m_haven) begin
        if (b == 8'd0 || int'(b) > MAX_WORDS_DEF) begin
          m_active = 0; m_err = 1;
        end else begin
          m_n = int'(b); m_haven = 1;
        end
      end else if (m_bytes.size() < 4 * m_n) begin
        m_bytes.push_back(b);
        sz = m_bytes.size();
        if (sz % 4 == 0) begin
          m_we    = 1'b1;
          m_ww    = sz / 4;
          m_addr  = 7'((m_ww - 1) * 4);
          m_wdata = {m_bytes[sz-4], m_bytes[sz-3], m_bytes[sz-2], m_bytes[sz-1]};
        end
      end else begin
        x = 8'h00;
        foreach (m_bytes[i]) x = x ^ m_bytes[i];
        m_active = 0;
        if (b == x) m_done = 1;
        else        m_err  = 1;
      end
    end
    #1;
    chk("mem_we",        64'(bus.mem_we),      64'(m_we));
    chk("mem_addr",      64'(bus.mem_addr),    64'(m_addr));
    chk("mem_wdata",     64'(bus.mem_wdata),   64'(m_wdata));
    chk("in_ready",      64'(bus.in_ready),    64'(1'b1));
    chk("cpu_hold",      64'(cpu_hold),        64'(m_active));
    chk("load_done",     64'(load_done),       64'(m_done));
    chk("load_error",    64'(load_error),      64'(m_err));
    chk("words_written", 64'(words_written),   64'(m_ww));
    chk("done_and_err",  64'(load_done & load_error), 64'(1'b0));
    if (bus.mem_we === 1'b1) wlog.push_back('{a: bus.mem_addr, d: bus.mem_wdata});
  end

  // Bytes are driven at negedge; each task call starts and ends on a negedge.
  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit gaps);
    foreach (f[i]) begin
      if (gaps) idle($urandom_range(0, 3));
      bus.in_valid = 1'b1;
      bus.in_data  = f[i];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic done, input logic err,
                              input int ww, input int nwr);
    chk({tag, "_done"},   64'(load_done),     64'(done));
    chk({tag, "_error"},  64'(load_error),    64'(err));
    chk({tag, "_hold"},   64'(cpu_hold),      64'(1'b0));
    chk({tag, "_ww"},     64'(words_written), 64'(ww));
    chk({tag, "_nwrite"}, 64'(wlog.size()),   64'(nwr));
  endtask

  initial begin
    logic [7:0] frm[$];
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("rst_we",    64'(bus.mem_we),    64'(0));
    chk("rst_addr",  64'(bus.mem_addr),  64'(0));
    chk("rst_wdata", 64'(bus.mem_wdata), 64'(0));
    chk("rst_ready", 64'(bus.in_ready),  64'(1));
    check_status("rst", 1'b0, 1'b0, 0, 0);

    // Single word, good checksum.
    wlog.delete();
    frm = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    send_frame(frm, 1'b0); idle(2);
    check_status("one", 1'b1, 1'b0, 1, 1);
    if (wlog.size() == 1) begin
      chk("one_addr", 64'(wlog[0].a), 64'(7'h00));
      chk("one_data", 64'(wlog[0].d), 64'(32'h12345678));
    end

    // Two words, second at address 4.
    wlog.delete();
    frm = '{8'hA5, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2D};
    send_frame(frm, 1'b0); idle(2);
    check_status("two", 1'b1, 1'b0, 2, 2);
    if (wlog.size() == 2) begin
      chk("two_addr0", 64'(wlog[0].a), 64'(7'h00));
      chk("two_data0", 64'(wlog[0].d), 64'(32'h20080005));
      chk("two_addr1", 64'(wlog[1].a), 64'(7'h04));
      chk("two_data1", 64'(wlog[1].d), 64'(32'h00000000));
    end

    // Bad counts: zero, then MAX_WORDS+1.
    wlog.delete();
    frm = '{8'hA5, 8'h00};
    send_frame(frm, 1'b0); idle(1);
    check_status("cnt0", 1'b0, 1'b1, 0, 0);
    frm = '{8'hA5, 8'h21};
    send_frame(frm, 1'b0); idle(1);
    check_status("cnt33", 1'b0, 1'b1, 0, 0);

    // Bad checksum: word stays written.
    wlog.delete();
    frm = '{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
    send_frame(frm, 1'b0); idle(2);
    check_status("badchk", 1'b0, 1'b1, 1, 1);
    if (wlog.size() == 1) chk("badchk_data", 64'(wlog[0].d), 64'(32'hDEADBEEF));

    // Reset after the second data byte.
    wlog.delete();
    frm = '{8'hA5, 8'h01, 8'h11, 8'h22};
    send_frame(frm, 1'b0);
    reset = 1'b1; repeat (2) @(negedge clk); reset = 1'b0;
    idle(2);
    check_status("rstmid", 1'b0, 1'b0, 0, 0);
    chk("rstmid_addr",  64'(bus.mem_addr),  64'(0));
    chk("rstmid_wdata", 64'(bus.mem_wdata), 64'(0));

    // Reset on the same edge as the fourth data byte: the pulse never appears.
    frm = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03};
    send_frame(frm, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = 8'h04; reset = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; reset = 1'b0;
    idle(2);
    check_status("rstpend", 1'b0, 1'b0, 0, 0);

    // Full frame after reset completes normally.
    frm = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    send_frame(frm, 1'b0); idle(2);
    check_status("after_rst", 1'b1, 1'b0, 1, 1);

    // Leading junk, sync value as data and as checksum, random gaps.
    wlog.delete();
    frm = '{8'hFF, 8'h00, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5};
    send_frame(frm, 1'b1); idle(2);
    check_status("gaps", 1'b1, 1'b0, 1, 1);
    if (wlog.size() == 1) begin
      chk("gaps_addr", 64'(wlog[0].a), 64'(7'h00));
      chk("gaps_data", 64'(wlog[0].d), 64'(32'h000000A5));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
